// File: rtl/conv_32_8_tx.sv
// 32-bit to 8-bit serializer with valid/ready on both sides.
// Build option: CONV_PREFETCH_EN accepts the next word during the last byte.
module conv_32_8_tx #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset_L,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   input  logic        ready_out,
   output logic [1:0]  byte_idx,
   output logic        last_out
);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_hold, w_hold_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic        r_live;
   logic        w_in_xfer, w_out_xfer;
   logic [1:0]  w_sel;

   // Holds ready_in low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) r_live <= 1'b0;
      else          r_live <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state <= S_IDLE;
         r_hold  <= 32'h0;
         r_idx   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

`ifdef CONV_PREFETCH_EN
   assign ready_in = r_live && ((r_state == S_IDLE) ||
                                (r_state == S_SEND && r_idx == 2'd3 && ready_out));
`else
   assign ready_in = r_live && (r_state == S_IDLE);
`endif

   assign valid_out  = (r_state == S_SEND);
   assign last_out   = valid_out && (r_idx == 2'd3);
   assign byte_idx   = r_idx;
   assign w_in_xfer  = valid_in && ready_in;
   assign w_out_xfer = valid_out && ready_out;

   // MSB-first order is the bit-inverse of the transmission index (3 - idx).
   assign w_sel    = LSB_FIRST ? r_idx : ~r_idx;
   assign data_out = valid_out ? r_hold[{w_sel, 3'b000} +: 8] : 8'h00;

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_idx_nxt   = r_idx;
      case (r_state)
         S_IDLE: begin
            if (w_in_xfer) begin
               w_hold_nxt  = data_in;
               w_idx_nxt   = 2'd0;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (w_out_xfer) begin
               if (r_idx == 2'd3) begin
                  w_idx_nxt = 2'd0;
                  if (w_in_xfer) w_hold_nxt  = data_in;
                  else           w_state_nxt = S_IDLE;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_32_8_tx.sv
// Directed bench for conv_32_8_tx: one LSB-first and one MSB-first instance
// share the same stimulus and are checked against hand-computed byte streams.
module tb_conv_32_8_tx;

   logic        clk = 1'b0;
   logic        reset_L;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;

   logic        rdy_l, rdy_m, vld_l, vld_m, last_l, last_m;
   logic [7:0]  dat_l, dat_m;
   logic [1:0]  idx_l, idx_m;

   int checks = 0;
   int errors = 0;

`ifdef CONV_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   always #5 clk = ~clk;

   conv_32_8_tx #(.LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_in(rdy_l), .data_out(dat_l), .valid_out(vld_l),
      .ready_out(ready_out), .byte_idx(idx_l), .last_out(last_l));

   conv_32_8_tx #(.LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_in(rdy_m), .data_out(dat_m), .valid_out(vld_m),
      .ready_out(ready_out), .byte_idx(idx_m), .last_out(last_m));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Both instances present a byte; bl/bm are the LSB-first/MSB-first expected bytes.
   task automatic exp_b(input string tag, input logic [7:0] bl, input logic [7:0] bm,
                        input logic [1:0] idx, input logic last);
      chk({tag, " data_l"}, {24'h0, dat_l}, {24'h0, bl});
      chk({tag, " data_m"}, {24'h0, dat_m}, {24'h0, bm});
      chk({tag, " idx_l"},  {30'h0, idx_l}, {30'h0, idx});
      chk({tag, " idx_m"},  {30'h0, idx_m}, {30'h0, idx});
      chk({tag, " valid"},  {30'h0, vld_l, vld_m}, 32'h3);
      chk({tag, " last"},   {30'h0, last_l, last_m}, {30'h0, last, last});
      chk({tag, " ready_in"}, {31'h0, rdy_l},
          {31'h0, PF && (idx == 2'd3) && ready_out});
   endtask

   task automatic exp_idle(input string tag, input logic rdy);
      chk({tag, " valid"}, {30'h0, vld_l, vld_m}, 32'h0);
      chk({tag, " data"},  {16'h0, dat_l, dat_m}, 32'h0);
      chk({tag, " last"},  {30'h0, last_l, last_m}, 32'h0);
      chk({tag, " ready_in"}, {30'h0, rdy_l, rdy_m}, {30'h0, rdy, rdy});
   endtask

   initial begin
      reset_L = 1'b0; data_in = 32'h0; valid_in = 1'b0; ready_out = 1'b1;
      #3;
      exp_idle("rst", 1'b0);
      chk("rst idx", {30'h0, idx_l, idx_m}, 32'h0);
      tick(); tick();
      reset_L = 1'b1;
      #2;
      exp_idle("rel", 1'b0);
      tick();
      exp_idle("rel+1", 1'b1);

      // Single word
      data_in = 32'hAABBCCDD; valid_in = 1'b1;
      tick();
      valid_in = 1'b0; data_in = 32'h0;
      exp_b("w1b0", 8'hDD, 8'hAA, 2'd0, 1'b0); tick();
      exp_b("w1b1", 8'hCC, 8'hBB, 2'd1, 1'b0); tick();
      exp_b("w1b2", 8'hBB, 8'hCC, 2'd2, 1'b0); tick();
      exp_b("w1b3", 8'hAA, 8'hDD, 2'd3, 1'b1); tick();
      exp_idle("w1end", 1'b1);

      // MSB-first order (dut_m)
      data_in = 32'h11223344; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      exp_b("w2b0", 8'h44, 8'h11, 2'd0, 1'b0); tick();
      exp_b("w2b1", 8'h33, 8'h22, 2'd1, 1'b0); tick();
      exp_b("w2b2", 8'h22, 8'h33, 2'd2, 1'b0); tick();
      exp_b("w2b3", 8'h11, 8'h44, 2'd3, 1'b1); tick();
      exp_idle("w2end", 1'b1);

      // Back-pressure at byte_idx 1
      data_in = 32'h44332211; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      exp_b("bpb0", 8'h11, 8'h44, 2'd0, 1'b0); tick();
      exp_b("bpb1", 8'h22, 8'h33, 2'd1, 1'b0);
      ready_out = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_b("bphold", 8'h22, 8'h33, 2'd1, 1'b0);
      end
      ready_out = 1'b1;
      tick();
      exp_b("bpb2", 8'h33, 8'h22, 2'd2, 1'b0); tick();
      exp_b("bpb3", 8'h44, 8'h11, 2'd3, 1'b1); tick();
      exp_idle("bpend", 1'b1);

      // Streaming two words with valid_in held high
      data_in = 32'h03020100; valid_in = 1'b1;
      tick();
      data_in = 32'h07060504;
      exp_b("s0", 8'h00, 8'h03, 2'd0, 1'b0); tick();
      exp_b("s1", 8'h01, 8'h02, 2'd1, 1'b0); tick();
      exp_b("s2", 8'h02, 8'h01, 2'd2, 1'b0); tick();
      exp_b("s3", 8'h03, 8'h00, 2'd3, 1'b1); tick();
      if (!PF) begin
         exp_idle("sgap", 1'b1);
         tick();
      end
      valid_in = 1'b0;
      exp_b("s4", 8'h04, 8'h07, 2'd0, 1'b0); tick();
      exp_b("s5", 8'h05, 8'h06, 2'd1, 1'b0); tick();
      exp_b("s6", 8'h06, 8'h05, 2'd2, 1'b0); tick();
      exp_b("s7", 8'h07, 8'h04, 2'd3, 1'b1); tick();
      exp_idle("send", 1'b1);

      // Reset in the middle of a word
      data_in = 32'hDEADBEEF; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      exp_b("rmb0", 8'hEF, 8'hDE, 2'd0, 1'b0); tick();
      exp_b("rmb1", 8'hBE, 8'hAD, 2'd1, 1'b0); tick();
      exp_b("rmb2", 8'hAD, 8'hBE, 2'd2, 1'b0);
      #2 reset_L = 1'b0;
      #1;
      exp_idle("rmasync", 1'b0);
      chk("rmasync idx", {30'h0, idx_l, idx_m}, 32'h0);
      tick();
      reset_L = 1'b1;
      #2;
      exp_idle("rmrel", 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_idle("rmquiet", 1'b1);
      end
      data_in = 32'h01020304; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      exp_b("rmn0", 8'h04, 8'h01, 2'd0, 1'b0); tick();
      exp_b("rmn1", 8'h03, 8'h02, 2'd1, 1'b0); tick();
      exp_b("rmn2", 8'h02, 8'h03, 2'd2, 1'b0); tick();
      exp_b("rmn3", 8'h01, 8'h04, 2'd3, 1'b1); tick();
      exp_idle("rmnend", 1'b1);

      // Input activity during SEND is ignored
      if (!PF) begin
         data_in = 32'hCAFEF00D; valid_in = 1'b1;
         tick();
         data_in = 32'h12345678;
         exp_b("ig0", 8'h0D, 8'hCA, 2'd0, 1'b0); tick();
         data_in = 32'h9ABCDEF0;
         exp_b("ig1", 8'hF0, 8'hFE, 2'd1, 1'b0); tick();
         data_in = 32'h55AA55AA;
         exp_b("ig2", 8'hFE, 8'hF0, 2'd2, 1'b0); tick();
         data_in = 32'hFFFFFFFF;
         exp_b("ig3", 8'hCA, 8'h0D, 2'd3, 1'b1);
         valid_in = 1'b0;
         tick();
         exp_idle("igend", 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_32_8_tx.md
CONV_32_8_TX -- requirements
Module: conv_32_8_tx

Interface
REQ-001 Parameter: LSB_FIRST, 1, byte order; 1 = bits [7:0] sent first, 0 = bits [31:24] sent first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  32  parallel word to serialize.
REQ-005 valid_in  input  1  data_in holds a valid word.
REQ-006 ready_in  output  1  block accepts a word this cycle; a transfer occurs when valid_in && ready_in.
REQ-007 data_out  output  8  current byte.
REQ-008 valid_out  output  1  data_out holds a valid byte.
REQ-009 ready_out  input  1  downstream accepts a byte; a byte transfer occurs when valid_out && ready_out.
REQ-010 byte_idx  output  2  index (0-3) of the byte on data_out, in transmission order.
REQ-011 last_out  output  1  high with valid_out when byte_idx == 3.

Function
REQ-012 The block SHALL implement two states: IDLE (no word held) and SEND (word held, bytes pending).
REQ-013 In IDLE: ready_in = 1, valid_out = 0; on an input transfer, latch data_in into a 32-bit holding register, clear byte_idx to 0, go to SEND.
REQ-014 In SEND: valid_out = 1; data_out = held byte selected by byte_idx and LSB_FIRST; input data_in and valid_in SHALL be ignored except as stated in REQ-020.
REQ-015 Latency: the first byte of a word SHALL appear on data_out the cycle after the input transfer.
REQ-016 On a byte transfer with byte_idx < 3: byte_idx increments by 1; the state remains SEND.
REQ-017 On a byte transfer with byte_idx == 3: byte_idx wraps to 0; the state returns to IDLE, unless REQ-020 applies.
REQ-018 With ready_out = 0: data_out, byte_idx, valid_out and last_out SHALL hold stable with no change (back-pressure).
REQ-019 data_out SHALL be 8'h00 whenever valid_out = 0.
REQ-020 Simultaneous last-byte transfer and input transfer (legal only under REQ-025): load the new word, set byte_idx to 0, and remain in SEND.
REQ-021 A word SHALL never be dropped, duplicated or reordered, and no byte SHALL be skipped.

Reset
REQ-022 While reset_L = 0, the outputs SHALL be forced immediately (asynchronously) as follows: state = IDLE, byte_idx = 0, holding register = 0, valid_out = 0, last_out = 0, data_out = 8'h00, ready_in = 0.
REQ-023 ready_in SHALL rise on the first clk edge after reset_L deasserts.
REQ-024 A reset asserted during SEND SHALL abandon the held word; after release the block SHALL emit no residual bytes.

Configuration
REQ-025 Macro CONV_PREFETCH_EN controls prefetch:
- Defined: ready_in = 1 in IDLE and also in SEND when byte_idx == 3 && ready_out == 1. Back-to-back words stream with no bubble, giving 4 bytes per 4 cycles.
- Undefined: ready_in = 1 only in IDLE. Each word costs 5 cycles, with one idle cycle between words.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Single word: with LSB_FIRST=1 and ready_out=1, send 32'hAABBCCDD -> data_out = DD,CC,BB,AA on 4 consecutive cycles starting 1 cycle after acceptance; last_out high only with AA.
- MSB first: with LSB_FIRST=0, send 32'h11223344 -> 11,22,33,44, byte_idx = 0,1,2,3.
- Back-pressure: drop ready_out for 3 cycles while byte_idx=1 -> data_out and byte_idx hold; the sequence resumes with no loss.
- Streaming: send words 32'h03020100 and 32'h07060504 with valid_in held high. With CONV_PREFETCH_EN the response is bytes 00..07 on 8 consecutive cycles. Without it, there is a 1-cycle valid_out=0 gap after byte 03.
- Reset mid-word: assert reset_L=0 after 2 bytes of 32'hDEADBEEF -> valid_out drops immediately. After release, no further bytes appear until a new word is accepted, and that word starts at byte_idx 0.
- Idle input ignored: toggle data_in in SEND with valid_in=1 and CONV_PREFETCH_EN undefined -> output bytes come only from the held word.
